fft_frame_buffer: RTL and testbench
===================================

Name: fft_frame_buffer

Overview:
- Upstream neighbour of the 8-point pipelined FFT (fft_top_1).
- Accepts a serial stream of 12-bit audio samples and keeps a sliding 8-sample window.
- Presents the window as 8 parallel, stable words to the FFT inputs x_0..x_7, with a frame strobe.
- Generates a delayed strobe that marks when the FFT outputs for that frame are valid.

Parameters:
- DATA_W, 12, sample and output word width.
- N, 8, window length (fixed by FFT size; only 8 supported).
- HOP, 8, new samples per emitted frame; legal 1..N (HOP<N gives overlap).
- OFFSET_BIN, 1, 1 = input is offset-binary ADC code, converted to two's complement by inverting the MSB; 0 = pass through.
- FFT_LAT, 3, cycles from x_* update to valid FFT outputs (three registered butterfly ranks).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: restart window fill.
- sample_in  in  DATA_W  audio sample.
- sample_valid  in  1  sample_in valid this cycle; no backpressure.
- x_0..x_7  out  DATA_W each  window to FFT; x_0 oldest, x_7 newest.
- frame_valid  out  1  one-cycle pulse: x_* just loaded with a new frame.
- fft_valid  out  1  frame_valid delayed exactly FFT_LAT cycles.
- fill_done  out  1  high once N samples have been accepted since reset or clr.

Behaviour:
- Reset (rst_n low, async): history registers, x_0..x_7, hop counter, fill counter, valid pipeline all 0; frame_valid=0, fft_valid=0, fill_done=0.
- Input conversion: s = OFFSET_BIN ? {~sample_in[DATA_W-1], sample_in[DATA_W-2:0]} : sample_in. No other arithmetic; width unchanged.
- History: 8-deep shift register h[0..7]. On each accepted sample (sample_valid=1 at the edge), shift h[i]<=h[i+1] and h[7]<=s.
- Fill counter: 0..N, saturates at N. fill_done = (fill==N), registered.
- Hop counter: 0..HOP-1. It increments per accepted sample and wraps to 0 when a frame is emitted. It only counts after the fill condition is met.
- Emit condition, evaluated at the accepting edge, using the post-shift window: (fill reaches N with this sample, i.e. first frame) OR (fill_done already 1 and hop==HOP-1).
- On emit, at the same edge: x_0..x_7 <= the post-shift window (including the new sample). The frame_valid register is set, so frame_valid is high for exactly the following cycle, aligned with the new x_*.
- Latency: sample on sample_valid at edge k → x_* and frame_valid visible after edge k; fft_valid high after edge k+FFT_LAT.
- x_* hold their value between frames; they are never modified without a frame_valid pulse.
- fft_valid: FFT_LAT-deep shift register fed by frame_valid. Back-to-back frames (HOP=1, continuous input) give back-to-back pulses with no loss.
- sample_valid may be high every cycle; gaps of any length are allowed.
- clr: fill, hop and history reset to 0; valid pipeline flushed; x_* retain their last value. clr has priority over sample_valid in the same cycle; that sample is discarded.
- After clr, the first frame again requires N fresh samples.
- HOP outside 1..N is a parameter error (elaboration assertion).

Decomposition:
- Shared package (audio_pkg): DATA_W, N, FFT_LAT constants and a sample_t typedef, shared with the FFT top and the downstream magnitude stage.
- One sub-module: valid_delay_line (parameter DEPTH, async active-low reset), reused to align strobes with other fixed-latency stages.
- The window/counter logic stays in the top module.

Test Plan:
- Reset mid-stream: assert rst_n low after 5 samples → all outputs 0 immediately without waiting for a clock; 8 more samples are needed before the first frame_valid.
- HOP=8, OFFSET_BIN=0, feed 1..16 continuously → frame_valid after the 8th and 16th samples; x_0..x_7 = 1..8, then 9..16; fft_valid 3 cycles after each pulse.
- HOP=2, feed 1..12 → frames after samples 8, 10, 12; x_0..x_7 = 1..8, 3..10, 5..12.
- OFFSET_BIN=1, feed 12'h800 ×8 → x_* all 12'h000; feed 12'hFFF ×8 → 12'h7FF; feed 12'h000 ×8 → 12'h800.
- Gapped input: sample_valid high every third cycle → same frame contents as continuous input; x_* stable between pulses.
- clr together with sample_valid after 7 samples → that sample is dropped; fill_done stays 0; a pending fft_valid is cancelled; the next frame requires 8 new samples.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio front-end constants and sample type.
// Used by the frame buffer, the FFT top and the magnitude stage.
package audio_pkg;

  localparam int DATA_W  = 12;
  localparam int N       = 8;
  localparam int FFT_LAT = 3;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth strobe delay used to align valids with pipelined stages.
// A synchronous clear flushes every stage.
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_pipe;

  if (DEPTH < 1) begin : g_depth_chk
    $error("valid_delay_line: DEPTH must be >= 1");
  end

  // Shift the strobe one stage per cycle; clear drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else if (clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign q = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_frame_buffer.sv
// Sliding 8-sample window feeding the 8-point FFT inputs x_0..x_7.
// Emits a frame every HOP samples once filled, plus an FFT-aligned strobe.
module fft_frame_buffer
  import audio_pkg::*;
#(
  parameter int DATA_W     = audio_pkg::DATA_W,
  parameter int N          = audio_pkg::N,
  parameter int HOP        = 8,
  parameter int OFFSET_BIN = 1,
  parameter int FFT_LAT    = audio_pkg::FFT_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] x_0,
  output logic [DATA_W-1:0] x_1,
  output logic [DATA_W-1:0] x_2,
  output logic [DATA_W-1:0] x_3,
  output logic [DATA_W-1:0] x_4,
  output logic [DATA_W-1:0] x_5,
  output logic [DATA_W-1:0] x_6,
  output logic [DATA_W-1:0] x_7,
  output logic              frame_valid,
  output logic              fft_valid,
  output logic              fill_done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_FULL = CW'(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_HOPL = CW'(HOP - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  if (HOP < 1 || HOP > N) begin : g_hop_chk
    $error("fft_frame_buffer: HOP must be in 1..N");
  end

  if (N != 8) begin : g_n_chk
    $error("fft_frame_buffer: only N=8 is supported");
  end

  logic [DATA_W-1:0] r_hist [N];
  logic [DATA_W-1:0] r_x    [N];
  logic [DATA_W-1:0] w_win  [N];
  logic [DATA_W-1:0] w_s;
  logic [CW-1:0]     r_fill;
  logic [CW-1:0]     r_hop;
  logic              r_fill_done;
  logic              r_fv;
  logic              w_acc;
  logic              w_first;
  logic              w_emit;
  logic              w_fft_valid;

  assign w_s = (OFFSET_BIN != 0)
             ? {~sample_in[DATA_W-1], sample_in[DATA_W-2:0]}
             : sample_in;

  assign w_acc   = sample_valid & ~clr;
  assign w_first = (r_fill == C_LAST);
  assign w_emit  = w_acc
                 & (w_first | (r_fill_done & (r_hop == C_HOPL)));

  // Window as it will look after shifting in the current sample.
  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      w_win[i] = r_hist[i+1];
    end
    w_win[N-1] = w_s;
  end

  // Fill and hop counters; hop only runs once the window is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill      <= '0;
      r_fill_done <= 1'b0;
      r_hop       <= '0;
    end else if (clr) begin
      r_fill      <= '0;
      r_fill_done <= 1'b0;
      r_hop       <= '0;
    end else if (sample_valid) begin
      if (r_fill != C_FULL) begin
        r_fill <= r_fill + C_ONE;
      end
      if (w_first) begin
        r_fill_done <= 1'b1;
      end
      if (w_emit) begin
        r_hop <= '0;
      end else if (r_fill_done) begin
        r_hop <= r_hop + C_ONE;
      end
    end
  end

  // History shift register; newest sample enters at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
    end else if (sample_valid) begin
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= w_win[i];
      end
    end
  end

  // Output window loads only on emit; the frame strobe follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_x[i] <= '0;
      end
      r_fv <= 1'b0;
    end else begin
      r_fv <= w_emit;
      if (w_emit) begin
        for (int i = 0; i < N; i++) begin
          r_x[i] <= w_win[i];
        end
      end
    end
  end

  valid_delay_line #(
    .DEPTH (FFT_LAT)
  ) u_fft_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .d     (r_fv),
    .q     (w_fft_valid)
  );

  assign x_0         = r_x[0];
  assign x_1         = r_x[1];
  assign x_2         = r_x[2];
  assign x_3         = r_x[3];
  assign x_4         = r_x[4];
  assign x_5         = r_x[5];
  assign x_6         = r_x[6];
  assign x_7         = r_x[7];
  assign frame_valid = r_fv;
  assign fft_valid   = w_fft_valid;
  assign fill_done   = r_fill_done;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer with three parameter sets.
// Instance 0: HOP=8 raw, 1: HOP=2 raw, 2: HOP=8 offset-binary.
module tb_fft_frame_buffer;

  localparam int W = 12;

  typedef struct packed {
    logic [1:0]    inst;
    logic [8*W-1:0] win;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic done  = 1'b0;

  always #5 clk = ~clk;

  logic [W-1:0] s_in   [3];
  logic         s_v    [3];
  logic         s_clr  [3];
  logic         s_emit [3];
  logic [W-1:0] xo     [3][8];
  logic         fv     [3];
  logic         ffv    [3];
  logic         fd     [3];

  exp_t         sb [$];
  logic [8*W-1:0] last [3];
  logic [3:0]   pe   [3];
  int           mfill[3];
  int           n_vec = 0;
  int           n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft_frame_buffer #(
      .DATA_W     (W),
      .N          (8),
      .HOP        ((g == 1) ? 2 : 8),
      .OFFSET_BIN ((g == 2) ? 1 : 0),
      .FFT_LAT    (3)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (s_clr[g]),
      .sample_in    (s_in[g]),
      .sample_valid (s_v[g]),
      .x_0          (xo[g][0]),
      .x_1          (xo[g][1]),
      .x_2          (xo[g][2]),
      .x_3          (xo[g][3]),
      .x_4          (xo[g][4]),
      .x_5          (xo[g][5]),
      .x_6          (xo[g][6]),
      .x_7          (xo[g][7]),
      .frame_valid  (fv[g]),
      .fft_valid    (ffv[g]),
      .fill_done    (fd[g])
    );
  end

  // Expected strobe pipeline and fill count, from the hand-marked emits.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        pe[k]    <= '0;
        mfill[k] <= 0;
      end else if (s_clr[k]) begin
        pe[k]    <= '0;
        mfill[k] <= 0;
      end else begin
        pe[k] <= {pe[k][2:0], s_v[k] & s_emit[k]};
        if (s_v[k] && mfill[k] < 8) mfill[k] <= mfill[k] + 1;
      end
    end
  end

  // Monitor: compare strobes, fill_done, frames and held windows.
  always @(negedge clk) begin : mon
    logic [8*W-1:0] aw;
    logic [1:0]     ea;
    logic [1:0]     aa;
    exp_t           e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) last[k] = '0;
      for (int j = 0; j < 8; j++) aw[j*W +: W] = xo[k][j];
      ea = {pe[k][0], pe[k][3]};
      aa = {fv[k], ffv[k]};
      n_vec++;
      if (aa !== ea) begin
        n_bad++;
        $display("FAIL strobe[%0d] fv,fft got %b want %b t=%0t",
                 k, aa, ea, $time);
      end
      n_vec++;
      if (fd[k] !== (mfill[k] == 8)) begin
        n_bad++;
        $display("FAIL fill_done[%0d] got %b want %b t=%0t",
                 k, fd[k], (mfill[k] == 8), $time);
      end
      if (fv[k] === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL frame_unexp[%0d] got %h want none t=%0t",
                   k, aw, $time);
        end else begin
          e = sb.pop_front();
          if (e.inst !== 2'(k) || e.win !== aw) begin
            n_bad++;
            $display("FAIL frame[%0d] got %h want %h (inst %0d) t=%0t",
                     k, aw, e.win, e.inst, $time);
          end
          last[k] = e.win;
        end
      end else begin
        n_vec++;
        if (aw !== last[k]) begin
          n_bad++;
          $display("FAIL x_hold[%0d] got %h want %h t=%0t",
                   k, aw, last[k], $time);
        end
      end
    end
    if (done) begin
      n_vec++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL frames_missing got %0d left want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  task automatic push(int k, logic [W-1:0] first, logic [W-1:0] step);
    exp_t e;
    e.inst = 2'(k);
    for (int j = 0; j < 8; j++) e.win[j*W +: W] = first + W'(j) * step;
    sb.push_back(e);
  endtask

  task automatic drv(int k, logic [W-1:0] v, logic val,
                     logic em, logic cl);
    @(posedge clk);
    #1;
    s_in[k]   = v;
    s_v[k]    = val;
    s_emit[k] = em;
    s_clr[k]  = cl;
  endtask

  task automatic idle(int k, int n);
    repeat (n) drv(k, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      s_in[k] = '0; s_v[k] = 1'b0; s_clr[k] = 1'b0; s_emit[k] = 1'b0;
      last[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(0, 2);

    // HOP=8, continuous 1..16
    push(0, 1, 1);
    push(0, 9, 1);
    for (int v = 1; v <= 16; v++)
      drv(0, W'(v), 1'b1, (v == 8 || v == 16), 1'b0);
    idle(0, 5);

    // HOP=2, 1..12
    push(1, 1, 1);
    push(1, 3, 1);
    push(1, 5, 1);
    for (int v = 1; v <= 12; v++)
      drv(1, W'(v), 1'b1, (v >= 8 && v % 2 == 0), 1'b0);
    idle(1, 5);

    // Offset-binary conversion
    push(2, 12'h000, 0);
    push(2, 12'h7FF, 0);
    push(2, 12'h800, 0);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++)
        drv(2, (r == 0) ? 12'h800 : (r == 1) ? 12'hFFF : 12'h000,
            1'b1, (i == 7), 1'b0);
    idle(2, 5);

    // Gapped input, one sample every third cycle
    push(0, 17, 1);
    push(0, 25, 1);
    for (int v = 17; v <= 32; v++) begin
      drv(0, W'(v), 1'b1, (v == 24 || v == 32), 1'b0);
      idle(0, 2);
    end
    idle(0, 4);

    // clr, 7 samples, clr with a sample that must be dropped
    drv(0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drv(0, W'(100 + i), 1'b1, 1'b0, 1'b0);
    drv(0, W'(107), 1'b1, 1'b0, 1'b1);
    idle(0, 3);
    push(0, 200, 1);
    for (int i = 0; i < 8; i++) drv(0, W'(200 + i), 1'b1, (i == 7), 1'b0);
    idle(0, 5);

    // clr right after a frame cancels its pending fft_valid
    push(1, 7, 1);
    drv(1, W'(13), 1'b1, 1'b0, 1'b0);
    drv(1, W'(14), 1'b1, 1'b1, 1'b0);
    drv(1, '0, 1'b0, 1'b0, 1'b1);
    idle(1, 4);
    push(1, 300, 1);
    for (int i = 0; i < 8; i++) drv(1, W'(300 + i), 1'b1, (i == 7), 1'b0);
    idle(1, 5);

    // Async reset mid-stream, then a full refill
    for (int i = 0; i < 5; i++) drv(2, W'(50 + i), 1'b1, 1'b0, 1'b0);
    idle(2, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(2, 12'h83C, 1);
    for (int i = 0; i < 8; i++) drv(2, W'(60 + i), 1'b1, (i == 7), 1'b0);
    idle(2, 6);
    done = 1'b1;
  end

endmodule
